vic_clk_enable_gen: RTL and testbench

VIC_CLK_ENABLE_GEN -- requirements
Module: vic_clk_enable_gen

---
 rtl/vic_clk_enable_gen.sv | 69 ++++++
 tb/tb_vic_clk_enable_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vic_clk_enable_gen.sv
// VIC-II clock-enable generator: stretched reset, dot-clock enable and phi0/phi2 phase decode.
// Optional define VIC_CLK_PAUSE_EN adds a pause input that halts the counter at a phi cycle boundary.
module vic_clk_enable_gen #(
    parameter int RST_CYCLES = 16
) (
    input  logic       clkin,
    input  logic       reset,
`ifdef VIC_CLK_PAUSE_EN
    input  logic       pause,
`endif
    output logic       rst_out,
    output logic       dot_ce,
    output logic       phi0,
    output logic       phi2_rise_ce,
    output logic       phi2_fall_ce,
    output logic [2:0] dot_phase
);

    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

    logic [7:0] rst_cnt;
    logic [5:0] phase;
    logic       halt;
    logic       stretching;
    logic       run;

    assign stretching = (rst_cnt != 8'd0);
    assign run        = !stretching && !halt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clkin) begin
        if (reset) begin
            rst_cnt <= RST_LOAD;
            phase   <= 6'd0;
        end else begin
            if (stretching)
                rst_cnt <= rst_cnt - 8'd1;
            // Natural 6-bit wrap gives the 63 -> 0 rollover with no gap.
            if (run)
                phase <= phase + 6'd1;
        end
    end

`ifdef VIC_CLK_PAUSE_EN
    // Halt is only entered on the phi2 falling enable, so the counter has
    // just wrapped to 0 and every enable is already low while halted.
    always_ff @(posedge clkin) begin
        if (reset)
            halt <= 1'b0;
        else if (halt) begin
            if (!pause)
                halt <= 1'b0;
        end else if (pause && phi2_fall_ce)
            halt <= 1'b1;
    end
`else
    assign halt = 1'b0;
`endif

    // Pure decode of registered state; no input reaches an output combinationally.
    assign rst_out      = stretching;
    assign dot_ce       = run && (phase[2:0] == 3'd7);
    assign phi2_rise_ce = run && (phase == 6'd31);
    assign phi2_fall_ce = run && (phase == 6'd63);
    assign phi0         = phase[5];
    assign dot_phase    = phase[5:3];

endmodule

// File: tb/tb_vic_clk_enable_gen.sv
// Randomized self-checking bench for vic_clk_enable_gen (RST_CYCLES = 16 and 1 side by side).
// Expected outputs come from a cycle-stamp model: phase = cycles elapsed since counting started, mod 64.
module tb_vic_clk_enable_gen;

`ifdef VIC_CLK_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clkin = 1'b0;
    logic reset = 1'b1;
    logic pause = 1'b0;

    logic       rst0, dot0, phi0_0, rise0, fall0;
    logic [2:0] dp0;
    logic       rst1, dot1, phi0_1, rise1, fall1;
    logic [2:0] dp1;

    always #5 clkin = ~clkin;

    vic_clk_enable_gen u_dut0 (
        .clkin(clkin), .reset(reset),
`ifdef VIC_CLK_PAUSE_EN
        .pause(pause),
`endif
        .rst_out(rst0), .dot_ce(dot0), .phi0(phi0_0), .phi2_rise_ce(rise0),
        .phi2_fall_ce(fall0), .dot_phase(dp0)
    );

    vic_clk_enable_gen #(.RST_CYCLES(1)) u_dut1 (
        .clkin(clkin), .reset(reset),
`ifdef VIC_CLK_PAUSE_EN
        .pause(pause),
`endif
        .rst_out(rst1), .dot_ce(dot1), .phi0(phi0_1), .phi2_rise_ce(rise1),
        .phi2_fall_ce(fall1), .dot_phase(dp1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: n counts clock edges; each instance remembers the edge of its last
    // reset, the edge at which counting (re)started, and whether it is halted.
    int n = 0;
    int rst_edge[2];
    int start_edge[2];
    bit halted[2];
    int rst_len[2] = '{16, 1};
    bit armed = 1'b0;

    function automatic bit m_rst(int i);
        return (n - rst_edge[i]) < rst_len[i];
    endfunction

    function automatic int m_c(int i);
        if (m_rst(i) || halted[i]) return 0;
        return (n - start_edge[i]) % 64;
    endfunction

    // {rst_out, phi0, dot_phase, dot_ce, phi2_rise_ce, phi2_fall_ce}
    function automatic logic [7:0] m_vec(int i);
        logic [5:0] cv;
        bit r, g;
        r  = m_rst(i);
        cv = 6'(m_c(i));
        g  = !r && !halted[i];
        return {r, cv[5], cv[5:3], g && (cv % 8 == 7), g && (cv == 31), g && (cv == 63)};
    endfunction

    function automatic void m_update(logic rst_v, logic pause_v);
        logic [7:0] pre[2];
        for (int i = 0; i < 2; i++) pre[i] = m_vec(i);
        n++;
        for (int i = 0; i < 2; i++) begin
            if (rst_v) begin
                rst_edge[i]   = n;
                start_edge[i] = n + rst_len[i];
                halted[i]     = 1'b0;
            end else if (PAUSE_EN) begin
                if (halted[i] && !pause_v) begin
                    halted[i]     = 1'b0;
                    start_edge[i] = n;
                end else if (!halted[i] && pause_v && pre[i][0]) begin
                    halted[i] = 1'b1;
                end
            end
        end
    endfunction

    // One clock: compare at the falling edge, drive, then advance the model on the rising edge.
    task automatic step(input logic rst_v, input logic pause_v);
        @(negedge clkin);
        if (armed) begin
            check("vec0", {24'd0, rst0, phi0_0, dp0, dot0, rise0, fall0}, {24'd0, m_vec(0)});
            check("vec1", {24'd0, rst1, phi0_1, dp1, dot1, rise1, fall1}, {24'd0, m_vec(1)});
        end
        reset = rst_v;
        pause = pause_v;
        @(posedge clkin);
        m_update(rst_v, pause_v);
        if (rst_v) armed = 1'b1;
        #1;
    endtask

    // Edges with reset low until each instance's rst_out drops (0 = never seen).
    task automatic measure_stretch(output int len0, output int len1);
        int k;
        len0 = 0;
        len1 = 0;
        k    = 0;
        do begin
            step(1'b0, 1'b0);
            k++;
            if (!rst1 && len1 == 0) len1 = k;
            if (!rst0 && len0 == 0) len0 = k;
        end while ((rst0 || rst1) && k < 300);
    endtask

    // Counted from the edge that started counting: the edge on which the first
    // dot_ce / phi2_rise_ce pulse is consumed by downstream logic.
    task automatic measure_first(output int dot_at, output int rise_at);
        int k;
        dot_at  = 0;
        rise_at = 0;
        k       = 0;
        while (rise_at == 0 && k < 100) begin
            k++;
            if (dot0 && dot_at == 0) dot_at = k;
            if (rise0 && rise_at == 0) rise_at = k;
            step(1'b0, 1'b0);
        end
    endtask

    int l0, l1, d_at, r_at, guard;
    logic pv;

    initial begin
        // Power-on: reset for 5 cycles, then release.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("reset_rst_out", {31'd0, rst0}, 32'd1);
        check("reset_phase", {28'd0, phi0_0, dp0}, 32'd0);
        check("reset_enables", {29'd0, dot0, rise0, fall0}, 32'd0);
        measure_stretch(l0, l1);
        check("stretch16", l0, 16);
        check("stretch1", l1, 1);
        check("first_cycle_c0", {28'd0, phi0_0, dp0, dot0}, 32'd0);
        measure_first(d_at, r_at);
        check("first_dot", d_at, 8);
        check("first_rise", r_at, 32);

        // Free run.
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0);

        // Reset mid-operation at c = 40.
        guard = 0;
        while (m_c(0) != 40 && guard < 100) begin step(1'b0, 1'b0); guard++; end
        check("reach_c40", m_c(0), 40);
        step(1'b1, 1'b0);
        check("midrst_rst_out", {31'd0, rst0}, 32'd1);
        check("midrst_phi0", {28'd0, phi0_0, dp0}, 32'd0);
        measure_stretch(l0, l1);
        check("restretch16", l0, 16);
        check("restretch1", l1, 1);

`ifdef VIC_CLK_PAUSE_EN
        // Pause raised mid-cycle at c = 10: halt after the next phi2 fall.
        guard = 0;
        while (m_c(0) != 10 && guard < 100) begin step(1'b0, 1'b0); guard++; end
        for (int i = 0; i < 120; i++) step(1'b0, 1'b1);
        check("paused_quiet", {27'd0, dot0, rise0, fall0, phi0_0, dp0 != 3'd0}, 32'd0);
        step(1'b0, 1'b0);
        measure_first(d_at, r_at);
        check("resume_dot", d_at, 8);
        check("resume_rise", r_at, 32);
`endif

        // Random traffic: occasional resets and (when present) pause bursts.
        pv = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39, 0) == 0) pv = ~pv;
            step($urandom_range(299, 0) == 0, pv);
        end
        step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
